instruction_fetch_unit: RTL and testbench

Requester side of the program memory interface: owns the program counter, drives the byte address into the word-indexed instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It delivers instructions to decode over a valid/ready handshake and accepts branch/jump redirects from later stages. It halts with a sticky fault on misaligned or out-of-range fetches.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_register.sv | 48 ++++
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 tb/tb_instruction_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: text segment base, NOP encoding
// and the instruction fetch state enum.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures instruction, PC and PC + 4 on enable,
// drops the valid bit on flush. Flush wins if both are asserted.
module if_id_register
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_plus4_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
    end else if (enable_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: program counter, ROM addressing, range checking and the
// FILL/RUN/HALT sequencing in front of the IF/ID register.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_pc_plus4,
  output logic                  fetch_fault
);

  localparam logic [DATA_WIDTH-1:0] ROM_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  capture;
  logic                  flush;

  function automatic logic is_legal(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] offset;
    offset = pc - TEXT_BASE;
    return (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && (offset < ROM_BYTES);
  endfunction

  assign pc_plus4     = pc_q + DATA_WIDTH'(4);
  assign imem_address = pc_q - TEXT_BASE;
  assign fetch_fault  = (state_q == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      pc_q    <= TEXT_BASE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A faulting PC is kept in pc_q for debug; in HALT a pending instruction may still drain.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FILL: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_target;
          if (!is_legal(redirect_target)) state_d = HALT;
        end else if (!id_valid || id_ready) begin
          if (!is_legal(pc_q)) begin
            flush   = 1'b1;
            state_d = HALT;
          end else begin
            capture = 1'b1;
            pc_d    = pc_plus4;
            if (!is_legal(pc_plus4)) state_d = HALT;
          end
        end
      end
      HALT: flush = id_ready;
      default: state_d = HALT;
    endcase
  end

  if_id_register #(.DATA_WIDTH(DATA_WIDTH)) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (capture),
    .flush_i   (flush),
    .instr_i   (imem_instruction),
    .pc_i      (pc_q),
    .pc_plus4_i(pc_plus4),
    .valid_o   (id_valid),
    .instr_o   (id_instruction),
    .pc_o      (id_pc),
    .pc_plus4_o(id_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector tables plus
// randomized traffic compared against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE      = 32'h0040_0000;
  localparam int          DEPTH     = 256;
  localparam int          ROM_BYTES = 4 * DEPTH;

  typedef struct {
    logic        redir;
    logic [31:0] target;
    logic        ready;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expAddr;
    logic        expFault;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;

  logic [31:0] rom [DEPTH];
  int          checks = 0;
  int          errors = 0;

  // Behavioural model of what decode should see
  bit          mFill, mHalt, mValid;
  logic [31:0] mPc, mInstr, mIdPc;

  instruction_fetch_unit #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .TEXT_BASE   (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instruction = (imem_address < ROM_BYTES) ? rom[imem_address[9:2]] : 32'hDEAD_BEEF;

  function automatic vec_t mk(logic r, logic [31:0] t, logic rd, logic v,
                              logic [31:0] pc, logic [31:0] addr, logic f);
    vec_t x;
    x.redir = r; x.target = t; x.ready = rd; x.expValid = v;
    x.expPc = pc; x.expAddr = addr; x.expFault = f;
    return x;
  endfunction

  function automatic logic [31:0] romAt(logic [31:0] pc);
    return rom[(pc - BASE) / 4];
  endfunction

  function automatic bit isLegal(logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= BASE) && ((pc - BASE) < ROM_BYTES);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] t, input logic rd);
    redirect_valid  = r;
    redirect_target = t;
    id_ready        = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd0);
    checkOutput({tag, "_instr"}, id_instruction, 32'd0);
    checkOutput({tag, "_pc"}, id_pc, 32'd0);
    checkOutput({tag, "_pc4"}, id_pc_plus4, 32'd0);
    checkOutput({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    checkOutput({tag, "_addr"}, imem_address, 32'd0);
  endtask

  task automatic modelReset();
    mFill = 1; mHalt = 0; mValid = 0; mPc = BASE; mInstr = '0; mIdPc = '0;
  endtask

  task automatic resetDut();
    redirect_valid = 0; redirect_target = '0; id_ready = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b1;
    modelReset();
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v.redir, v.target, v.ready);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'(v.expValid));
    checkOutput({tag, "_addr"}, imem_address, v.expAddr);
    checkOutput({tag, "_fault"}, 32'(fetch_fault), 32'(v.expFault));
    if (v.expValid) begin
      checkOutput({tag, "_pc"}, id_pc, v.expPc);
      checkOutput({tag, "_pc4"}, id_pc_plus4, v.expPc + 32'd4);
      checkOutput({tag, "_instr"}, id_instruction, romAt(v.expPc));
    end
  endtask

  // Expected effect of one clock edge given the inputs presented before it
  task automatic modelStep(input bit r, input logic [31:0] t, input bit rd);
    if (mHalt) begin
      if (mValid && rd) mValid = 0;
    end else if (mFill) begin
      mFill = 0;
    end else if (r) begin
      mValid = 0;
      mPc    = t;
      if (!isLegal(t)) mHalt = 1;
    end else if (!mValid || rd) begin
      mValid = 1;
      mIdPc  = mPc;
      mInstr = romAt(mPc);
      mPc    = mPc + 4;
      if (!isLegal(mPc)) mHalt = 1;
    end
  endtask

  task automatic checkModel();
    checkOutput("rnd_valid", 32'(id_valid), 32'(mValid));
    checkOutput("rnd_fault", 32'(fetch_fault), 32'(mHalt));
    checkOutput("rnd_addr", imem_address, mPc - BASE);
    if (mValid) begin
      checkOutput("rnd_pc", id_pc, mIdPc);
      checkOutput("rnd_pc4", id_pc_plus4, mIdPc + 32'd4);
      checkOutput("rnd_instr", id_instruction, mInstr);
    end
  endtask

  vec_t mainVecs[15];
  vec_t ovfVecs[7];
  vec_t rangeVecs[3];

  initial begin
    bit          r, rd;
    logic [31:0] t;
    int          haltCycles;

    foreach (rom[i]) rom[i] = $urandom;
    rom[0] = 32'h2008_0001;
    rom[1] = 32'h2009_0002;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'h0000_0000;

    mainVecs[0]  = mk(0, 0,             1, 0, 0,             32'h00, 0);
    mainVecs[1]  = mk(0, 0,             1, 1, 32'h0040_0000, 32'h04, 0);
    mainVecs[2]  = mk(0, 0,             1, 1, 32'h0040_0004, 32'h08, 0);
    mainVecs[3]  = mk(0, 0,             0, 1, 32'h0040_0004, 32'h08, 0);
    mainVecs[4]  = mk(0, 0,             0, 1, 32'h0040_0004, 32'h08, 0);
    mainVecs[5]  = mk(0, 0,             0, 1, 32'h0040_0004, 32'h08, 0);
    mainVecs[6]  = mk(0, 0,             1, 1, 32'h0040_0008, 32'h0C, 0);
    mainVecs[7]  = mk(0, 0,             0, 1, 32'h0040_0008, 32'h0C, 0);
    mainVecs[8]  = mk(1, 32'h0040_0010, 0, 0, 0,             32'h10, 0);
    mainVecs[9]  = mk(0, 0,             0, 1, 32'h0040_0010, 32'h14, 0);
    mainVecs[10] = mk(0, 0,             1, 1, 32'h0040_0014, 32'h18, 0);
    mainVecs[11] = mk(1, 32'h0040_0006, 1, 0, 0,             32'h06, 1);
    mainVecs[12] = mk(1, 32'h0040_0000, 1, 0, 0,             32'h06, 1);
    mainVecs[13] = mk(0, 0,             1, 0, 0,             32'h06, 1);
    mainVecs[14] = mk(0, 0,             0, 0, 0,             32'h06, 1);

    ovfVecs[0] = mk(0, 0,             1, 0, 0,             32'h000, 0);
    ovfVecs[1] = mk(1, 32'h0040_03F8, 1, 0, 0,             32'h3F8, 0);
    ovfVecs[2] = mk(0, 0,             1, 1, 32'h0040_03F8, 32'h3FC, 0);
    ovfVecs[3] = mk(0, 0,             1, 1, 32'h0040_03FC, 32'h400, 1);
    ovfVecs[4] = mk(0, 0,             0, 1, 32'h0040_03FC, 32'h400, 1);
    ovfVecs[5] = mk(0, 0,             1, 0, 0,             32'h400, 1);
    ovfVecs[6] = mk(1, 32'h0040_0000, 1, 0, 0,             32'h400, 1);

    rangeVecs[0] = mk(0, 0,             1, 0, 0, 32'h0,         0);
    rangeVecs[1] = mk(1, 32'h0030_0000, 1, 0, 0, 32'hFFF0_0000, 1);
    rangeVecs[2] = mk(1, 32'h0040_0000, 1, 0, 0, 32'hFFF0_0000, 1);

    resetDut();
    foreach (mainVecs[i]) runVec($sformatf("main%0d", i), mainVecs[i]);

    resetDut();
    foreach (ovfVecs[i]) runVec($sformatf("ovf%0d", i), ovfVecs[i]);

    resetDut();
    foreach (rangeVecs[i]) runVec($sformatf("range%0d", i), rangeVecs[i]);

    resetDut();
    haltCycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (mHalt && haltCycles > 4) begin
        resetDut();
        haltCycles = 0;
      end
      r  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       t = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
        1:       t = $urandom;
        2, 3, 4: t = BASE + 32'($urandom_range(DEPTH - 8, DEPTH - 1) * 4);
        default: t = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      applyStimulus(r, t, rd);
      modelStep(r, t, rd);
      checkModel();
      if (mHalt) haltCycles++;
    end

    // Asynchronous reset in the middle of a cycle, then a clean restart
    resetDut();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(0, 0, 1);
      modelStep(0, 0, 1);
      checkModel();
    end
    #1;
    reset = 1'b0;
    #1;
    checkResetValues("async");
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) runVec($sformatf("restart%0d", i), mainVecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
